// File: rtl/simon_key_schedule_serial_if.sv
// Control and serial key-stream signals between the Simon datapath/host and
// the bit-serial key schedule.
interface simon_key_schedule_serial_if;
  logic       load;
  logic       data_in;
  logic       stall;
  logic       key_out;
  logic       key_valid;
  logic       key_first;
  logic [6:0] round_idx;
  logic       round_odd;
  logic       busy;
  logic       done;

  modport master (
    output load, data_in, stall,
    input  key_out, key_valid, key_first, round_idx, round_odd, busy, done
  );

  modport slave (
    input  load, data_in, stall,
    output key_out, key_valid, key_first, round_idx, round_odd, busy, done
  );
endinterface

// File: rtl/simon_key_schedule_serial.sv
// Bit-serial Simon key expansion: serial master-key load, then one round-key
// bit per non-stalled cycle while the next key word is formed alongside.
module simon_key_schedule_serial #(
  parameter int WORD_SIZE = 64,
  parameter int KEY_WORDS = 2,
  parameter int ROUNDS    = 68,
  parameter int Z_INDEX   = 2
) (
  input logic                        clk,
  input logic                        rst_n,
  simon_key_schedule_serial_if.slave bus
);
  localparam int N  = WORD_SIZE;
  localparam int M  = KEY_WORDS;
  localparam int KW = M * N;

  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [5:0]      r_bit_cnt;
  logic [1:0]      r_word_cnt;
  logic [6:0]      r_round;
  logic [KW-1:0]   r_key;

  logic w_step;
  logic w_last_bit;
  logic w_last_word;
  logic w_last_round;
  logic w_t3;
  logic w_t4;
  logic w_k1;
  logic w_const;
  logic w_new_bit;

  // Sequence characters are written leftmost-first, so character j is bit 61-j.
  function automatic logic z_bit(input logic [6:0] idx);
    logic [6:0]  j;
    logic [61:0] seq;
    int unsigned pos;
    j = (idx >= 7'd62) ? (idx - 7'd62) : idx;
    case (Z_INDEX)
      0:       seq = Z0;
      1:       seq = Z1;
      2:       seq = Z2;
      3:       seq = Z3;
      4:       seq = Z4;
      default: seq = Z0;
    endcase
    pos = 32'd61 - 32'(j);
    return seq[pos];
  endfunction

  assign w_step       = (r_state == ST_RUN) && !bus.stall && !bus.load;
  assign w_last_bit   = (r_bit_cnt == 6'(N - 1));
  assign w_last_word  = (r_word_cnt == 2'(M - 1));
  assign w_last_round = (r_round == 7'(ROUNDS - 1));

  // Window holds k(i)..k(i+m-1) with k(i) bit j at position 0; the wrapped
  // low bits of k(i+m-1) have slid one word down, hence the alternate taps.
  always_comb begin
    w_t3    = 1'b0;
    w_t4    = 1'b0;
    w_k1    = 1'b0;
    w_const = 1'b1;
    if (r_bit_cnt >= 6'(N - 3)) w_t3 = r_key[(M-2)*N + 3];
    else                        w_t3 = r_key[(M-1)*N + 3];
    if (r_bit_cnt >= 6'(N - 4)) w_t4 = r_key[(M-2)*N + 4];
    else                        w_t4 = r_key[(M-1)*N + 4];
    if (M == 4) begin
      if (w_last_bit) w_k1 = r_key[N] ^ r_key[1];
      else            w_k1 = r_key[N] ^ r_key[N + 1];
    end else begin
      w_k1 = 1'b0;
    end
    if (r_bit_cnt == 6'd0)      w_const = z_bit(r_round);
    else if (r_bit_cnt == 6'd1) w_const = 1'b0;
    else                        w_const = 1'b1;
    w_new_bit = w_const ^ r_key[0] ^ w_t3 ^ w_t4 ^ w_k1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.load) begin
      w_next_state = ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE: w_next_state = ST_IDLE;
        ST_LOAD: w_next_state = (w_last_bit && w_last_word) ? ST_RUN : ST_LOAD;
        ST_RUN:  w_next_state = (w_step && w_last_bit && w_last_round) ? ST_DONE : ST_RUN;
        ST_DONE: w_next_state = ST_DONE;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= 6'd0;
      r_word_cnt <= 2'd0;
      r_round    <= 7'd0;
    end else if (bus.load) begin
      r_bit_cnt  <= 6'd0;
      r_word_cnt <= 2'd0;
      r_round    <= 7'd0;
    end else if (r_state == ST_LOAD) begin
      if (w_last_bit) begin
        r_bit_cnt  <= 6'd0;
        r_word_cnt <= w_last_word ? 2'd0 : (r_word_cnt + 2'd1);
      end else begin
        r_bit_cnt  <= r_bit_cnt + 6'd1;
      end
    end else if (w_step) begin
      if (w_last_bit) begin
        r_bit_cnt <= 6'd0;
        r_round   <= w_last_round ? r_round : (r_round + 7'd1);
      end else begin
        r_bit_cnt <= r_bit_cnt + 6'd1;
      end
    end else begin
      r_bit_cnt  <= r_bit_cnt;
      r_word_cnt <= r_word_cnt;
      r_round    <= r_round;
    end
  end

  // Key storage is deliberately unreset: every run starts with a full reload.
  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD && !bus.load) r_key <= {bus.data_in, r_key[KW-1:1]};
    else if (w_step)                     r_key <= {w_new_bit, r_key[KW-1:1]};
    else                                 r_key <= r_key;
  end

  assign bus.key_valid = w_step;
  assign bus.key_out   = w_step & r_key[0];
  assign bus.key_first = w_step & (r_bit_cnt == 6'd0);
  assign bus.round_idx = r_round;
  assign bus.round_odd = r_round[0];
  assign bus.busy      = (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign bus.done      = (r_state == ST_DONE);
endmodule

// File: tb/tb_simon_key_schedule_serial.sv
// Scoreboard bench: two schedule instances (Simon128/128 and Simon64/128 shapes)
// checked bit-by-bit against a word-level key-expansion model.
module tb_simon_key_schedule_serial;
  localparam int NA = 64, MA = 2, RA = 68, ZA = 2;
  localparam int NB = 32, MB = 4, RB = 44, ZB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  simon_key_schedule_serial_if bus_a ();
  simon_key_schedule_serial_if bus_b ();

  simon_key_schedule_serial #(.WORD_SIZE(NA), .KEY_WORDS(MA), .ROUNDS(RA), .Z_INDEX(ZA))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  simon_key_schedule_serial #(.WORD_SIZE(NB), .KEY_WORDS(MB), .ROUNDS(RB), .Z_INDEX(ZB))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic [1:0]      ld, din, st;
  logic [1:0]      vld, kout, kfst, rodd, bsy, dne;
  logic [1:0][6:0] ridx;

  assign bus_a.load = ld[0];  assign bus_a.data_in = din[0];  assign bus_a.stall = st[0];
  assign bus_b.load = ld[1];  assign bus_b.data_in = din[1];  assign bus_b.stall = st[1];
  assign vld[0]  = bus_a.key_valid;  assign vld[1]  = bus_b.key_valid;
  assign kout[0] = bus_a.key_out;    assign kout[1] = bus_b.key_out;
  assign kfst[0] = bus_a.key_first;  assign kfst[1] = bus_b.key_first;
  assign rodd[0] = bus_a.round_odd;  assign rodd[1] = bus_b.round_odd;
  assign bsy[0]  = bus_a.busy;       assign bsy[1]  = bus_b.busy;
  assign dne[0]  = bus_a.done;       assign dne[1]  = bus_b.done;
  assign ridx[0] = bus_a.round_idx;  assign ridx[1] = bus_b.round_idx;

  typedef struct packed {
    logic       b;
    logic       first;
    logic [6:0] ridx;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  string zs [0:4] = '{
    "11111010001001010110000111001101111101000100101011000011100110",
    "10001110111110010011000010110101000111011111001001100001011010",
    "10101111011100000011010010011000101000010001111110010110110011",
    "11011011101011000110010111100000010010001010011100110100001111",
    "11010001111001101011011000100000010111000011001010010011101111"
  };

  logic [63:0] kz   [4] = '{64'h0, 64'h0, 64'h0, 64'h0};
  logic [63:0] k128 [4] = '{64'h0706050403020100, 64'h0f0e0d0c0b0a0908, 64'h0, 64'h0};
  logic [63:0] k64  [4] = '{64'h03020100, 64'h0b0a0908, 64'h13121110, 64'h1b1a1918};
  logic [63:0] kr   [4];
  int          cyc;

  task automatic check(input int sel, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d) at %0t: got %0h, expected %0h", name, sel, $time, act, exp);
    end
  endtask

  function automatic int qsize(input int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qclear(input int sel);
    if (sel == 0) q0.delete();
    else          q1.delete();
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int r, input int n);
    logic [63:0] mask;
    mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    return ((x >> r) | (x << (n - r))) & mask;
  endfunction

  // Round key idx of the full schedule, computed word-at-a-time.
  function automatic logic [63:0] model_word(input int sel, input logic [63:0] kin [4], input int idx);
    int          n, m, zi;
    logic [63:0] mask, t;
    logic [63:0] k [0:79];
    n  = (sel == 0) ? NA : NB;
    m  = (sel == 0) ? MA : MB;
    zi = (sel == 0) ? ZA : ZB;
    mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    for (int i = 0; i < 80; i++) k[i] = 64'h0;
    for (int i = 0; i < m; i++) k[i] = kin[i] & mask;
    for (int i = 0; i + m <= idx; i++) begin
      t = rotr(k[i+m-1], 3, n);
      if (m == 4) t = t ^ k[i+1];
      t = t ^ rotr(t, 1, n);
      k[i+m] = (mask - 64'd3) ^ k[i] ^ t ^ ((zs[zi][i % 62] == "1") ? 64'd1 : 64'd0);
    end
    return k[idx];
  endfunction

  task automatic push_model(input int sel, input logic [63:0] kin [4]);
    int          n, r_total;
    logic [63:0] w;
    exp_t        e;
    n       = (sel == 0) ? NA : NB;
    r_total = (sel == 0) ? RA : RB;
    for (int r = 0; r < r_total; r++) begin
      w = model_word(sel, kin, r);
      for (int b = 0; b < n; b++) begin
        e.b = w[b];
        e.first = (b == 0);
        e.ridx = 7'(r);
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
      end
    end
  endtask

  task automatic do_load(input int sel, input logic [63:0] kin [4]);
    int n, m;
    n = (sel == 0) ? NA : NB;
    m = (sel == 0) ? MA : MB;
    @(posedge clk); #1;
    ld[sel] = 1'b1;
    qclear(sel);
    @(posedge clk); #1;
    ld[sel] = 1'b0;
    for (int w = 0; w < m; w++) begin
      for (int b = 0; b < n; b++) begin
        din[sel] = kin[w][b];
        if (!(w == m - 1 && b == n - 1)) begin
          @(posedge clk); #1;
        end
      end
    end
    push_model(sel, kin);
  endtask

  task automatic wait_done(input int sel, input int bound);
    int c;
    c = 0;
    while (dne[sel] !== 1'b1 && c < bound) begin
      @(negedge clk);
      c++;
    end
    check(sel, "done_reached", 64'(dne[sel]), 64'd1);
    check(sel, "done_quiet", 64'({bsy[sel], vld[sel]}), 64'd0);
    check(sel, "stream_consumed", 64'(qsize(sel)), 64'd0);
  endtask

  task automatic run_stalled(input int sel, input int bound);
    int c;
    c = 0;
    while (dne[sel] !== 1'b1 && c < bound) begin
      @(posedge clk); #1;
      st[sel] = ($urandom_range(0, 99) < 30);
      c++;
    end
    st[sel] = 1'b0;
    wait_done(sel, 10);
  endtask

  task automatic check_reset(input int sel);
    check(sel, "reset_outputs",
          64'({vld[sel], kout[sel], kfst[sel], ridx[sel], rodd[sel], bsy[sel], dne[sel]}), 64'd0);
  endtask

  task automatic rand_key();
    for (int i = 0; i < 4; i++) kr[i] = {$urandom, $urandom};
  endtask

  // Scoreboard monitor: every valid bit must match the head of the expected stream.
  always @(negedge clk) begin
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      if (vld[s] === 1'b1) begin
        if (qsize(s) == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid (dut %0d) at %0t: got key_valid=1, expected no valid bit", s, $time);
        end else begin
          if (s == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check(s, "key_bit", 64'({kout[s], kfst[s], ridx[s], rodd[s]}),
                64'({e.b, e.first, e.ridx, e.ridx[0]}));
        end
      end else begin
        check(s, "invalid_outputs_low", 64'({kout[s], kfst[s]}), 64'd0);
      end
    end
  end

  initial begin
    ld = 2'b00; din = 2'b00; st = 2'b00;
    #1 rst_n = 1'b0;
    #20;
    check_reset(0);
    check_reset(1);
    @(posedge clk); #1 rst_n = 1'b1;

    // All-zero key: model sanity, latency, exact run length.
    check(0, "model_k2", model_word(0, kz, 2), 64'hFFFF_FFFF_FFFF_FFFD);
    do_load(0, kz);
    @(negedge clk);
    check(0, "last_load_cycle", 64'({bsy[0], vld[0]}), 64'b10);
    @(negedge clk);
    check(0, "first_run_bit", 64'({vld[0], kfst[0], ridx[0]}), 64'({1'b1, 1'b1, 7'd0}));
    cyc = 1;
    while (dne[0] !== 1'b1 && cyc < RA * NA + 20) begin
      @(negedge clk);
      if (dne[0] !== 1'b1) cyc++;
    end
    check(0, "run_length", 64'(cyc), 64'(RA * NA));
    wait_done(0, 10);

    do_load(0, k128);
    wait_done(0, RA * NA + 20);
    do_load(1, k64);
    wait_done(1, RB * NB + 20);

    rand_key();
    do_load(0, kr);
    run_stalled(0, 3 * RA * NA);
    rand_key();
    do_load(1, kr);
    run_stalled(1, 3 * RB * NB);

    // Abort at round 5 with a fresh key.
    rand_key();
    do_load(0, kr);
    cyc = 0;
    while (!(vld[0] === 1'b1 && ridx[0] == 7'd5) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check(0, "reached_round5", 64'(ridx[0]), 64'd5);
    rand_key();
    do_load(0, kr);
    wait_done(0, RA * NA + 20);

    // Reset during LOAD.
    @(posedge clk); #1 ld[1] = 1'b1;
    @(posedge clk); #1 ld[1] = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset(1);
    check_reset(0);
    qclear(1);
    @(posedge clk); #1 rst_n = 1'b1;
    rand_key();
    do_load(1, kr);
    wait_done(1, RB * NB + 20);

    // Reset during RUN.
    rand_key();
    do_load(0, kr);
    repeat (200) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset(0);
    qclear(0);
    @(posedge clk); #1 rst_n = 1'b1;
    rand_key();
    do_load(0, kr);
    run_stalled(0, 3 * RA * NA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
